game_timer: RTL

Multi-channel, single-clock timer for the BlackJack game FSM. It replaces the separate 2 kHz clock domain with an internal prescaler tick. It provides N independent channels, each one-shot or auto-reload with a programmable limit; the 2-second dealer/display delays are one such channel. It also carries an optional free-running seed counter for the card shuffler. It sits between the top-level FSM and the display/shuffle logic.

---
 rtl/game_timer_pkg.sv | 14 +
 rtl/timer_channel.sv | 70 +++++++
 rtl/game_timer.sv | 75 +++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game timer: channel states and prescaler divisor.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE state, tick count, done pulse and sticky expired flag.
module timer_channel
  import game_timer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_50M,
  input  logic             i_Zero,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  ch_state_t        state;
  logic [WIDTH-1:0] lim;
  logic             per;

  // Stop outranks start, start outranks a tick; ack is applied first so a done in the same cycle keeps expired set.
  always_ff @(posedge clk_50M or posedge i_Zero) begin
    if (i_Zero) begin
      state   <= ST_IDLE;
      count   <= '0;
      lim     <= '0;
      per     <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ack) expired <= 1'b0;
      if (stop) begin
        if (state != ST_IDLE) state <= ST_IDLE;
      end else if (start) begin
        count   <= '0;
        lim     <= limit;
        per     <= periodic & (limit != '0);
        expired <= 1'b0;
        if (limit == '0) begin
          state   <= ST_DONE;
          done    <= 1'b1;
          expired <= 1'b1;
        end else begin
          state <= ST_RUN;
        end
      end else if (state == ST_RUN && tick) begin
        if (count == lim - 1'b1) begin
          done    <= 1'b1;
          expired <= 1'b1;
          if (per) begin
            count <= '0;
          end else begin
            count <= lim;
            state <= ST_DONE;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: rtl/game_timer.sv
// Multi-channel game timer: free-running prescaler tick, N_CH channels, optional seed counter.
// Define GAME_TIMER_SEED_EN to build the seed counter; otherwise o_Seed is tied to 0.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2000,
  parameter int WIDTH   = 12,
  parameter int N_CH    = 2
) (
  input  logic                  clk_50M,
  input  logic                  i_Zero,
  input  logic [N_CH-1:0]       i_Start,
  input  logic [N_CH-1:0]       i_Stop,
  input  logic [N_CH-1:0]       i_Periodic,
  input  logic [N_CH*WIDTH-1:0] i_Limit,
  input  logic [N_CH-1:0]       i_Ack,
  input  logic                  i_SeedEn,
  output logic                  o_Tick,
  output logic [N_CH*WIDTH-1:0] o_Count,
  output logic [N_CH-1:0]       o_Busy,
  output logic [N_CH-1:0]       o_Done,
  output logic [N_CH-1:0]       o_Expired,
  output logic [WIDTH-1:0]      o_Seed
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc;

  // Free-running prescaler; the tick is registered on the wrap edge and channels consume it one cycle later.
  always_ff @(posedge clk_50M or posedge i_Zero) begin
    if (i_Zero) begin
      presc  <= '0;
      o_Tick <= 1'b0;
    end else begin
      o_Tick <= (presc == PRESC_MAX);
      presc  <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_50M  (clk_50M),
      .i_Zero   (i_Zero),
      .tick     (o_Tick),
      .start    (i_Start[k]),
      .stop     (i_Stop[k]),
      .periodic (i_Periodic[k]),
      .limit    (i_Limit[k*WIDTH +: WIDTH]),
      .ack      (i_Ack[k]),
      .count    (o_Count[k*WIDTH +: WIDTH]),
      .busy     (o_Busy[k]),
      .done     (o_Done[k]),
      .expired  (o_Expired[k])
    );
  end

`ifdef GAME_TIMER_SEED_EN
  logic [WIDTH-1:0] seed;

  always_ff @(posedge clk_50M or posedge i_Zero) begin
    if (i_Zero) seed <= '0;
    else if (i_SeedEn) seed <= seed + 1'b1;
  end

  assign o_Seed = seed;
`else
  // Masking keeps the enable input connected while the output stays constant zero.
  assign o_Seed = {WIDTH{1'b0}} & {WIDTH{i_SeedEn}};
`endif

endmodule
